// File: rtl/dm_bridge_pkg.sv
// Shared definitions for the data-memory bridge: memory-op encodings,
// FSM state encodings and small decode helpers.
package dm_bridge_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [3:0] BE_ALL = 4'b1111;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_load(input logic [2:0] op);
    return !is_store(op);
  endfunction

  // Halfword accesses must be 2-byte aligned, word accesses 4-byte aligned.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: mis = off[0];
      OP_LW, OP_SW:         mis = (off != 2'b00);
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dm_bridge_load_ext.sv
// Load result formatting: picks the addressed byte/halfword out of the
// memory word (little-endian) and sign- or zero-extends it to 32 bits.
module dm_bridge_load_ext
  import dm_bridge_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [1:0]  off,
  input  logic [31:0] dm_rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = dm_rdata[{off, 3'b000} +: 8];
  assign half_sel = off[1] ? dm_rdata[31:16] : dm_rdata[15:0];

  // Extend the selected lane according to the load type.
  always_comb begin
    result = '0;
    case (mem_op)
      OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  result = {24'h000000, byte_sel};
      OP_LH:   result = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  result = {16'h0000, half_sel};
      OP_LW:   result = dm_rdata;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dm_bridge.sv
// MEM-stage bridge to a handshaked data memory. Latches one access, drives
// the request until granted, waits for read data on loads and returns a
// one-cycle completion pulse with the extended load result.
// Optional feature: define DM_ADDR_EXC_EN to trap misaligned halfword/word
// accesses without touching memory (addr_exc flagged with resp_valid).
module dm_bridge
  import dm_bridge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        mem_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              resp_valid,
  output logic [31:0]       rdata,
  output logic              dm_req,
  output logic              dm_we,
  output logic [3:0]        dm_be,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [31:0]       dm_rdata,
  output logic              addr_exc
);

  state_e            state_reg, state_next;
  logic [2:0]        op_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rdata_reg;
  logic [31:0]       ext_result;
  logic [1:0]        off;
  logic              accept;
  logic              exc_now;
  logic [3:0]        be_steer;
  logic [31:0]       wdata_steer;

  assign off    = addr_reg[1:0];
  assign accept = (state_reg == ST_IDLE) && req_valid;

`ifdef DM_ADDR_EXC_EN
  logic exc_reg;
  assign exc_now = is_misaligned(mem_op, addr[1:0]);
`else
  assign exc_now = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: a trapped access goes straight to DONE; stores finish
  // on grant, loads additionally wait for read data (rvalid ignored in REQ).
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (req_valid) state_next = exc_now ? ST_DONE : ST_REQ;
      ST_REQ:  if (dm_gnt)    state_next = is_store(op_reg) ? ST_DONE : ST_WAIT;
      ST_WAIT: if (dm_rvalid) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Capture the access on acceptance so memory-side signals stay stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_reg    <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (accept) begin
      op_reg    <= mem_op;
      addr_reg  <= addr;
      wdata_reg <= wdata;
    end
  end

`ifdef DM_ADDR_EXC_EN
  // Remember whether the accepted access was trapped as misaligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      exc_reg <= 1'b0;
    else if (accept) exc_reg <= exc_now;
  end
`endif

  // Load result register: cleared per access, loaded when read data arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  rdata_reg <= '0;
    else if (accept)                             rdata_reg <= '0;
    else if (state_reg == ST_WAIT && dm_rvalid)  rdata_reg <= ext_result;
  end

  dm_bridge_load_ext u_load_ext (
    .mem_op   (op_reg),
    .off      (off),
    .dm_rdata (dm_rdata),
    .result   (ext_result)
  );

  // Per-lane store steering: byte enable and replicated data for each lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic       lane_be;
    logic [7:0] lane_data;

    // Lane enable/data selection by store width.
    always_comb begin
      lane_be   = 1'b1;
      lane_data = 8'h00;
      case (op_reg)
        OP_SB: begin
          lane_be   = (off == LANE);
          lane_data = wdata_reg[7:0];
        end
        OP_SH: begin
          lane_be   = (off[1] == LANE[1]);
          lane_data = wdata_reg[8*(gi%2) +: 8];
        end
        OP_SW: begin
          lane_be   = 1'b1;
          lane_data = wdata_reg[8*gi +: 8];
        end
        default: begin
          lane_be   = 1'b1;
          lane_data = 8'h00;
        end
      endcase
    end

    assign be_steer[gi]           = lane_be;
    assign wdata_steer[8*gi +: 8] = lane_data;
  end

  // Outputs decoded from registered state only; memory signals quiet outside REQ.
  assign req_ready  = (state_reg == ST_IDLE);
  assign busy       = (state_reg == ST_REQ) || (state_reg == ST_WAIT);
  assign dm_req     = (state_reg == ST_REQ);
  assign dm_we      = dm_req && is_store(op_reg);
  assign dm_be      = dm_req ? (is_store(op_reg) ? be_steer : BE_ALL) : 4'b0000;
  assign dm_addr    = dm_req ? {addr_reg[ADDR_W-1:2], 2'b00} : '0;
  assign dm_wdata   = dm_req ? wdata_steer : 32'h0;
  assign resp_valid = (state_reg == ST_DONE);
  assign rdata      = resp_valid ? rdata_reg : 32'h0;

`ifdef DM_ADDR_EXC_EN
  assign addr_exc = resp_valid && exc_reg;
`else
  assign addr_exc = 1'b0;
`endif

endmodule

// File: tb/tb_dm_bridge.sv
// Directed self-checking bench for dm_bridge.
module tb_dm_bridge;
  import dm_bridge_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        addr_exc;

  int checks = 0;
  int errors = 0;

  dm_bridge #(.ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .mem_op     (mem_op),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .resp_valid (resp_valid),
    .rdata      (rdata),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_be      (dm_be),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_gnt     (dm_gnt),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .addr_exc   (addr_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++;
    if ({req_ready, busy, resp_valid, dm_req, dm_we, addr_exc} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 100000", {req_ready, busy, resp_valid, dm_req, dm_we, addr_exc});
    end
    checks++;
    if ({rdata, dm_addr, dm_wdata, dm_be} !== 100'h0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h dm_addr=%h dm_wdata=%h dm_be=%b want all 0", rdata, dm_addr, dm_wdata, dm_be);
    end
    $display("test_reset done");
  endtask

  task automatic test_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd,
                            input logic [31:0] exp_addr, input string nm);
    req_valid = 1'b1; mem_op = op; addr = a; wdata = d; dm_gnt = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL %s_ready: got %b want 1", nm, req_ready); end
    tick;
    req_valid = 1'b0; wdata = 32'h0; addr = 32'h0;
    checks++;
    if ({dm_req, dm_we, busy, resp_valid} !== 4'b1110) begin
      errors++; $display("FAIL %s_req_ctrl: got %b want 1110", nm, {dm_req, dm_we, busy, resp_valid});
    end
    checks++;
    if (dm_be !== exp_be) begin errors++; $display("FAIL %s_be: got %b want %b", nm, dm_be, exp_be); end
    checks++;
    if (dm_wdata !== exp_wd) begin errors++; $display("FAIL %s_wdata: got %h want %h", nm, dm_wdata, exp_wd); end
    checks++;
    if (dm_addr !== exp_addr) begin errors++; $display("FAIL %s_addr: got %h want %h", nm, dm_addr, exp_addr); end
    tick;
    dm_gnt = 1'b0;
    checks++;
    if ({resp_valid, dm_req, busy, addr_exc} !== 4'b1000 || rdata !== 32'h0) begin
      errors++; $display("FAIL %s_resp: got ctrl=%b rdata=%h want 1000 rdata=0", nm, {resp_valid, dm_req, busy, addr_exc}, rdata);
    end
    tick;
    checks++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL %s_idle: got %b want 01", nm, {resp_valid, req_ready});
    end
    $display("store %s addr=%h wdata=%h be=%b", nm, a, d, exp_be);
  endtask

  // Load with grant on first REQ cycle; a spurious rvalid accompanies the
  // grant and must be ignored in favour of the data presented in WAIT.
  task automatic test_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] word,
                           input logic [31:0] exp, input string nm);
    req_valid = 1'b1; mem_op = op; addr = a;
    tick;
    req_valid = 1'b0; addr = 32'h0;
    checks++;
    if ({dm_req, dm_we, dm_be} !== 6'b101111 || dm_addr !== {a[31:2], 2'b00}) begin
      errors++; $display("FAIL %s_req: got req/we/be=%b addr=%h want 101111 %h", nm, {dm_req, dm_we, dm_be}, dm_addr, {a[31:2], 2'b00});
    end
    dm_gnt = 1'b1; dm_rvalid = 1'b1; dm_rdata = ~word;
    tick;
    dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = word;
    checks++;
    if ({busy, dm_req, resp_valid} !== 3'b100) begin
      errors++; $display("FAIL %s_wait: got %b want 100", nm, {busy, dm_req, resp_valid});
    end
    tick;
    dm_rvalid = 1'b0; dm_rdata = 32'h0;
    checks++;
    if (resp_valid !== 1'b1 || rdata !== exp) begin
      errors++; $display("FAIL %s_rdata: got valid=%b rdata=%h want 1 %h", nm, resp_valid, rdata, exp);
    end
    tick;
    checks++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL %s_idle: got %b want 01", nm, {resp_valid, req_ready});
    end
    $display("load %s addr=%h word=%h rdata=%h", nm, a, word, exp);
  endtask

  task automatic test_wait_states;
    int pulses = 0;
    req_valid = 1'b1; mem_op = OP_LW; addr = 32'h0000_2000;
    tick;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({dm_req, busy, resp_valid} !== 3'b110) begin
        errors++; $display("FAIL ws_req_hold%0d: got %b want 110", i, {dm_req, busy, resp_valid});
      end
      tick;
    end
    dm_gnt = 1'b1;
    tick;
    dm_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({dm_req, busy, resp_valid} !== 3'b010) begin
        errors++; $display("FAIL ws_wait%0d: got %b want 010", i, {dm_req, busy, resp_valid});
      end
      tick;
    end
    dm_rvalid = 1'b1; dm_rdata = 32'h8001_1234;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL ws_busy_last: got %b want 1", busy); end
    tick;
    dm_rvalid = 1'b0; dm_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid === 1'b1) begin
        pulses++;
        checks++;
        if (rdata !== 32'h8001_1234) begin errors++; $display("FAIL ws_rdata: got %h want 80011234", rdata); end
      end
      tick;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL ws_pulses: got %0d want 1", pulses); end
    $display("load LW wait-states gnt+3 rvalid+2 pulses=%0d", pulses);
  endtask

  task automatic test_reset_mid_wait;
    int pulses = 0;
    req_valid = 1'b1; mem_op = OP_LW; addr = 32'h0000_4000;
    tick;
    req_valid = 1'b0; dm_gnt = 1'b1;
    tick;
    dm_gnt = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b want 1", busy); end
    reset = 1'b0;
    #1;
    checks++;
    if ({req_ready, busy, resp_valid, dm_req, dm_be, rdata, dm_addr} !== {4'b1000, 4'b0000, 64'h0}) begin
      errors++; $display("FAIL rst_mid: ready/busy/resp/req=%b be=%b rdata=%h addr=%h want 1000 0 0 0", {req_ready, busy, resp_valid, dm_req}, dm_be, rdata, dm_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    dm_rvalid = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (resp_valid !== 1'b0) pulses++;
    end
    dm_rvalid = 1'b0;
    checks++;
    if (pulses != 0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_no_resp: pulses=%0d ready=%b want 0 1", pulses, req_ready);
    end
    $display("reset during WAIT pulses=%0d", pulses);
  endtask

  task automatic test_misaligned;
`ifdef DM_ADDR_EXC_EN
    req_valid = 1'b1; mem_op = OP_SW; addr = 32'h0000_1002; wdata = 32'hCAFE_F00D;
    tick;
    req_valid = 1'b0;
    checks++;
    if ({dm_req, resp_valid, addr_exc, busy} !== 4'b0110 || rdata !== 32'h0) begin
      errors++; $display("FAIL exc_sw: got req/resp/exc/busy=%b rdata=%h want 0110 0", {dm_req, resp_valid, addr_exc, busy}, rdata);
    end
    tick;
    checks++;
    if ({resp_valid, addr_exc, req_ready} !== 3'b001) begin
      errors++; $display("FAIL exc_idle: got %b want 001", {resp_valid, addr_exc, req_ready});
    end
    $display("misaligned SW addr=00001002 trapped");
`else
    test_store(OP_SW, 32'h0000_1002, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 32'h0000_1000, "SW_mis");
    checks++;
    if (addr_exc !== 1'b0) begin errors++; $display("FAIL noexc: got %b want 0", addr_exc); end
`endif
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; mem_op = 3'b000; addr = 32'h0; wdata = 32'h0;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
    #2;
    test_reset;
    tick;
    reset = 1'b1;
    tick;
    test_store(OP_SB, 32'h0000_1003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, 32'h0000_1000, "SB");
    test_store(OP_SB, 32'h0000_1001, 32'h1234_5677, 4'b0010, 32'h7777_7777, 32'h0000_1000, "SB1");
    test_store(OP_SH, 32'h0000_2002, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF, 32'h0000_2000, "SH");
    test_store(OP_SH, 32'h0000_2000, 32'h0000_8001, 4'b0011, 32'h8001_8001, 32'h0000_2000, "SH0");
    test_store(OP_SW, 32'h0000_3000, 32'h1234_5678, 4'b1111, 32'h1234_5678, 32'h0000_3000, "SW");
    test_load(OP_LB,  32'h0000_1002, 32'h12F0_3456, 32'hFFFF_FFF0, "LB");
    test_load(OP_LBU, 32'h0000_1002, 32'h12F0_3456, 32'h0000_00F0, "LBU");
    test_load(OP_LB,  32'h0000_1000, 32'h12F0_3456, 32'h0000_0056, "LB0");
    test_load(OP_LH,  32'h0000_1002, 32'h8001_1234, 32'hFFFF_8001, "LH");
    test_load(OP_LHU, 32'h0000_1002, 32'h8001_1234, 32'h0000_8001, "LHU");
    test_load(OP_LH,  32'h0000_1000, 32'h8001_9234, 32'hFFFF_9234, "LH0");
    test_load(OP_LW,  32'h0000_1000, 32'h8001_1234, 32'h8001_1234, "LW");
    test_wait_states;
    test_reset_mid_wait;
    test_misaligned;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
